// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice mixer: sample width, FSM state type
// and the signed saturation function used by the clip logic.
package synth_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } mixer_state_t;

    // Clamp a signed value to the range of a width-bit signed number.
    function automatic logic signed [DATA_W-1:0] sat_s(input logic signed [31:0] value,
                                                       input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return DATA_W'(hi);
        end else if (value < lo) begin
            return DATA_W'(lo);
        end
        return DATA_W'(value);
    endfunction

endpackage

// File: rtl/mix_scaler.sv
// Combinational headroom shift, master-volume multiply and output clip.
// MIXER_SATURATE_EN selects clamping; otherwise the result wraps to DATA_W bits.
module mix_scaler #(
    parameter int DATA_W    = synth_pkg::DATA_W,
    parameter int ACC_W     = DATA_W + 3,
    parameter int VOL_W     = 8,
    parameter int MIX_SHIFT = 2
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [VOL_W-1:0]  volume,
    output logic [DATA_W-1:0] sample
);
    import synth_pkg::*;

    localparam int P_W = ACC_W + VOL_W + 1;

    logic signed [ACC_W-1:0] shifted;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   r;

    always_comb begin
        shifted = $signed(acc) >>> MIX_SHIFT;
        // Volume is unsigned, so it gets a zero sign bit before the signed multiply.
        prod    = P_W'(shifted) * P_W'($signed({1'b0, volume}));
        r       = prod >>> VOL_W;
`ifdef MIXER_SATURATE_EN
        sample  = DATA_W'(sat_s(32'(r), DATA_W));
`else
        sample  = DATA_W'(r);
`endif
    end

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: snapshots all voices on an accepted sample tick, sums them one per
// clock, scales via mix_scaler and presents the sample on a valid/ready handshake.
//
//  state | meaning
//  IDLE  | waiting for a sample tick
//  ACCUM | adding one snapshotted voice per clock
//  SCALE | shift/volume/clip of the sum into the output register
//  OUT   | sample_valid high until the consumer takes the sample
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int DATA_W     = synth_pkg::DATA_W,
    parameter int VOL_W      = 8,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES*DATA_W-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic [VOL_W-1:0]             volume,
    output logic [DATA_W-1:0]            sample_out,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic [7:0]                   overrun_cnt
);
    import synth_pkg::*;

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = DATA_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    mixer_state_t                 state_q, state_d;
    logic [NUM_VOICES*DATA_W-1:0] voice_q, voice_d;
    logic [NUM_VOICES-1:0]        en_q, en_d;
    logic [VOL_W-1:0]             vol_q, vol_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DATA_W-1:0]            sample_q, sample_d;
    logic [7:0]                   ovr_q, ovr_d;

    logic                         accept;
    logic signed [DATA_W-1:0]     cur_voice;
    logic [DATA_W-1:0]            scaled;

    mix_scaler #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .VOL_W     (VOL_W),
        .MIX_SHIFT (MIX_SHIFT)
    ) u_scaler (
        .acc    (acc_q),
        .volume (vol_q),
        .sample (scaled)
    );

    always_comb begin
        accept    = sample_tick &&
                    ((state_q == IDLE) || ((state_q == OUT) && sample_ready));
        cur_voice = $signed(voice_q[int'(idx_q)*DATA_W +: DATA_W]);

        state_d  = state_q;
        voice_d  = voice_q;
        en_d     = en_q;
        vol_d    = vol_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        ovr_d    = ovr_q;

        if (sample_tick && !accept && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ACCUM: begin
                if (en_q[idx_q]) begin
                    acc_d = acc_q + ACC_W'(cur_voice);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                sample_d = scaled;
                state_d  = OUT;
            end
            OUT: begin
                if (sample_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted tick overrides the OUT->IDLE return for back-to-back mixes.
        if (accept) begin
            voice_d = voice_in;
            en_d    = voice_en;
            vol_d   = volume;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            voice_q  <= '0;
            en_q     <= '0;
            vol_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            sample_q <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            voice_q  <= voice_d;
            en_q     <= en_d;
            vol_q    <= vol_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = (state_q == OUT);
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed mixes with literal expectations
// plus a per-cycle comparison against a sample-level behavioural model.
module tb_voice_mixer;

    localparam int NV  = 8;
    localparam int DW  = 16;
    localparam int LAT = NV + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [NV*DW-1:0] voice_in;
    logic [NV-1:0]   en;
    logic [7:0]      vol;
    logic            ready;
    logic [DW-1:0]   sample_out;
    logic            sample_valid;
    logic [7:0]      overrun_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    voice_mixer dut (
        .Clk          (clk),
        .Reset        (rst),
        .sample_tick  (tick),
        .voice_in     (voice_in),
        .voice_en     (en),
        .volume       (vol),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (ready),
        .overrun_cnt  (overrun_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample-level reference: sum of enabled voices, shift, volume, clip or wrap.
    function automatic logic [15:0] model_mix(input logic [NV*DW-1:0] v,
                                              input logic [NV-1:0] e,
                                              input logic [7:0] g);
        longint s;
        logic [63:0] bits;
        s = 0;
        for (int k = 0; k < NV; k++) begin
            if (e[k]) s += longint'($signed(v[k*DW +: DW]));
        end
        s = s >>> 2;
        s = s * longint'(g);
        s = s >>> 8;
`ifdef MIXER_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        bits = s;
        return bits[15:0];
    endfunction

    logic        m_valid = 1'b0;
    logic [15:0] m_out   = '0;
    logic [15:0] m_pend  = '0;
    logic [7:0]  m_ovr   = '0;
    int          m_busy  = 0;
    logic        m_accept;

    assign m_accept = tick && ((!m_valid && (m_busy == 0)) || (m_valid && ready));

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
            m_ovr   <= '0;
        end else begin
            if (m_valid && ready) m_valid <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1;
                    m_out   <= m_pend;
                end
            end
            if (m_accept) begin
                m_pend <= model_mix(voice_in, en, vol);
                m_busy <= LAT;
            end else if (tick && (m_ovr != 8'hFF)) begin
                m_ovr <= m_ovr + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_valid", sample_valid, m_valid);
            check("cyc_ovr", overrun_cnt, m_ovr);
            if (m_valid) check("cyc_out", sample_out, m_out);
        end
    end

    task automatic set_all(input logic [15:0] v);
        for (int k = 0; k < NV; k++) voice_in[k*DW +: DW] = v;
    endtask

    task automatic tick_once();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!sample_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sample_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: no sample_valid within %0d cycles", n);
        end
    endtask

    task automatic take();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic run_mix(input string name, input logic [15:0] exp, input bit scramble);
        int n;
        tick_once();
        if (scramble) begin
            for (int k = 0; k < NV; k++) voice_in[k*DW +: DW] = 16'($urandom);
            en  = 8'hFF;
            vol = 8'hFF;
        end
        wait_valid(n);
        check({name, "_latency"}, n, LAT);
        check(name, sample_out, exp);
        take();
    endtask

    initial begin
        int n;
        rst = 1'b1; tick = 1'b0; ready = 1'b0;
        voice_in = '0; en = '0; vol = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_on = 1'b1;
        check("rst_out", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_ovr", overrun_cnt, 0);
        rst = 1'b0;

        set_all(16'h1000); en = 8'hFF; vol = 8'd255;
        run_mix("t1_unity", 16'h1FE0, 1'b0);

        set_all(16'h7FFF); voice_in[3*DW +: DW] = 16'h4000; en = 8'h08; vol = 8'd128;
        run_mix("t2_mask_vol", 16'h0800, 1'b1);

        set_all(16'h7FFF); en = 8'hFF; vol = 8'd255;
`ifdef MIXER_SATURATE_EN
        run_mix("t3_clip_pos", 16'h7FFF, 1'b0);
        set_all(16'h8000);
        run_mix("t3_clip_neg", 16'h8000, 1'b0);
`else
        run_mix("t3_wrap_pos", 16'hFEFE, 1'b0);
        set_all(16'h8000);
        run_mix("t3_wrap_neg", 16'h0100, 1'b0);
`endif
        set_all(16'hF000);
        run_mix("t_negative", 16'hE020, 1'b0);
        set_all(16'h7FFF); vol = 8'd0;
        run_mix("t_vol_zero", 16'h0000, 1'b0);
        vol = 8'd255; en = 8'h00;
        run_mix("t_all_off", 16'h0000, 1'b0);

        set_all(16'h0100); en = 8'hFF; vol = 8'd255;
        tick_once();
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_valid(n);
        check("t4_out", sample_out, 16'h01FE);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_stall_out", sample_out, 16'h01FE);
            check("t4_stall_valid", sample_valid, 1);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("t4_ovr2", overrun_cnt, 2);
        set_all(16'h1000);
        ready = 1'b1; tick = 1'b1;
        @(negedge clk);
        ready = 1'b0; tick = 1'b0;
        check("t4_b2b_valid", sample_valid, 0);
        check("t4_b2b_ovr", overrun_cnt, 2);
        wait_valid(n);
        check("t4_b2b_latency", n, LAT);
        check("t4_b2b_out", sample_out, 16'h1FE0);
        check("t4_b2b_ovr_end", overrun_cnt, 2);
        take();

        set_all(16'h2000); en = 8'hFF; vol = 8'd200;
        tick_once();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_out", sample_out, 0);
        check("t5_rst_valid", sample_valid, 0);
        check("t5_rst_ovr", overrun_cnt, 0);
        repeat (15) @(negedge clk);
        check("t5_no_valid", sample_valid, 0);
        set_all(16'h1000); vol = 8'd255;
        run_mix("t5_after_rst", 16'h1FE0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
